kpad_uart_ctrl: RTL

- Parametrised keypad-to-serial controller. Scans an NROWS x NCOLS active-low matrix, debounces presses and releases, and encodes one code per press.
- Codes are queued in a small FIFO and sent 8N1 by an internal UART running off the system clock through a baud divider.
- Replaces the fixed 4x4 scan / decode / UART trio. Removes the separate baud PLL output. Adds buffering and overflow reporting.

---
 rtl/kpad_uart_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/kpad_uart_ctrl.sv
// Keypad matrix scanner with debounce, key FIFO and 8N1 UART transmitter.
// Optional feature macro: KPAD_ASCII_EN -- when defined, each queued code is
// sent as an ASCII hex digit ('0'-'9', 'A'-'F', '?' for codes above 15);
// otherwise the raw 8-bit code is sent. key_code is unaffected either way.
module kpad_uart_ctrl #(
   parameter int unsigned NROWS      = 4,
   parameter int unsigned NCOLS      = 4,
   parameter int unsigned SCAN_DIV   = 50000,
   parameter int unsigned DEB_CNT    = 4,
   parameter int unsigned BAUD_DIV   = 5208,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NROWS-1:0]              kpr,
   output logic [NCOLS-1:0]              kpc,
   output logic                          kphit,
   output logic                          key_valid,
   output logic [7:0]                    key_code,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          ovf_clr,
   output logic                          TX,
   output logic                          tx_busy
);

   localparam int unsigned ROW_W  = (NROWS > 1) ? $clog2(NROWS) : 1;
   localparam int unsigned COL_W  = (NCOLS > 1) ? $clog2(NCOLS) : 1;
   localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DEB_W  = $clog2(DEB_CNT + 1);
   localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;

   typedef enum logic [1:0] {S_SCAN, S_CONFIRM, S_HELD, S_RELEASE} scan_st_t;
   typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_st_t;

   // Byte placed on the wire for a queued key code.
   function automatic logic [7:0] tx_encode(input logic [7:0] code);
`ifdef KPAD_ASCII_EN
      if (code < 8'd10)      return 8'h30 + code;
      else if (code < 8'd16) return 8'h37 + code;
      else                   return 8'h3F;
`else
      return code;
`endif
   endfunction

   // ---------------------------------------------------------------- rows
   logic [NROWS-1:0] kpr_q1, kpr_q2;
   logic [3:0]       low_cnt;
   logic [ROW_W-1:0] low_row;
   logic             one_low, all_high;

   // Two-flop synchroniser; rows idle high out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kpr_q1 <= '1;
         kpr_q2 <= '1;
      end else begin
         kpr_q1 <= kpr;
         kpr_q2 <= kpr_q1;
      end
   end

   // Classify the synchronised row pattern.
   always_comb begin
      low_cnt = 4'd0;
      low_row = '0;
      for (int i = 0; i < int'(NROWS); i++) begin
         if (!kpr_q2[i]) begin
            low_cnt = low_cnt + 4'd1;
            low_row = ROW_W'(i);
         end
      end
      one_low  = (low_cnt == 4'd1);
      all_high = &kpr_q2;
   end

   // ---------------------------------------------------------------- scan
   scan_st_t         scan_st, scan_st_n;
   logic [COL_W-1:0] col, col_n, col_inc;
   logic [DIV_W-1:0] div_cnt, div_n;
   logic [DEB_W-1:0] deb_cnt, deb_n, deb_inc;
   logic [ROW_W-1:0] key_row, key_row_n;
   logic [NCOLS-1:0] kpc_n;
   logic [7:0]       key_code_n, code_c;
   logic             kphit_n, key_valid_n, sample;

   assign sample  = (div_cnt == DIV_W'(SCAN_DIV - 1));
   assign col_inc = (col == COL_W'(NCOLS - 1)) ? '0 : col + COL_W'(1);
   assign deb_inc = deb_cnt + DEB_W'(1);
   assign code_c  = 8'(low_row) * 8'(NCOLS) + 8'(col);

   // Scan state register and registered keypad outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scan_st   <= S_SCAN;
         col       <= '0;
         div_cnt   <= '0;
         deb_cnt   <= '0;
         key_row   <= '0;
         kpc       <= ~NCOLS'(1);
         kphit     <= 1'b0;
         key_valid <= 1'b0;
         key_code  <= 8'd0;
      end else begin
         scan_st   <= scan_st_n;
         col       <= col_n;
         div_cnt   <= div_n;
         deb_cnt   <= deb_n;
         key_row   <= key_row_n;
         kpc       <= kpc_n;
         kphit     <= kphit_n;
         key_valid <= key_valid_n;
         key_code  <= key_code_n;
      end
   end

   // Scan next-state: act only on the row sample at the end of each dwell.
   always_comb begin
      scan_st_n   = scan_st;
      col_n       = col;
      deb_n       = deb_cnt;
      key_row_n   = key_row;
      kphit_n     = kphit;
      key_valid_n = 1'b0;
      key_code_n  = key_code;
      div_n       = sample ? '0 : div_cnt + DIV_W'(1);
      if (sample) begin
         case (scan_st)
            S_SCAN: begin
               if (one_low) begin
                  if (DEB_CNT == 1) begin
                     key_valid_n = 1'b1;
                     key_code_n  = code_c;
                     kphit_n     = 1'b1;
                     scan_st_n   = S_HELD;
                  end else begin
                     scan_st_n = S_CONFIRM;
                     deb_n     = DEB_W'(1);
                     key_row_n = low_row;
                  end
               end else begin
                  col_n = col_inc;
               end
            end
            S_CONFIRM: begin
               if (one_low && (low_row == key_row)) begin
                  deb_n = deb_inc;
                  if (deb_inc == DEB_W'(DEB_CNT)) begin
                     key_valid_n = 1'b1;
                     key_code_n  = code_c;
                     kphit_n     = 1'b1;
                     scan_st_n   = S_HELD;
                  end
               end else begin
                  scan_st_n = S_SCAN;
                  col_n     = col_inc;
               end
            end
            S_HELD: begin
               if (all_high) begin
                  if (DEB_CNT == 1) begin
                     kphit_n   = 1'b0;
                     scan_st_n = S_SCAN;
                     col_n     = col_inc;
                  end else begin
                     scan_st_n = S_RELEASE;
                     deb_n     = DEB_W'(1);
                  end
               end
            end
            S_RELEASE: begin
               if (all_high) begin
                  deb_n = deb_inc;
                  if (deb_inc == DEB_W'(DEB_CNT)) begin
                     kphit_n   = 1'b0;
                     scan_st_n = S_SCAN;
                     col_n     = col_inc;
                  end
               end else begin
                  scan_st_n = S_HELD;
               end
            end
            default: scan_st_n = S_SCAN;
         endcase
      end
      kpc_n = ~(NCOLS'(1) << col_n);
   end

   // ---------------------------------------------------------------- fifo
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             full, push_ok, pop_c;

   assign full    = (fifo_level == LVL_W'(FIFO_DEPTH));
   assign push_ok = key_valid && (!full || pop_c);

   // Key storage; no reset needed, occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= key_code;
   end

   // Pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)   rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_ok && !pop_c)      fifo_level <= fifo_level + LVL_W'(1);
         else if (!push_ok && pop_c) fifo_level <= fifo_level - LVL_W'(1);
         if (key_valid && full && !pop_c) overflow <= 1'b1;
         else if (ovf_clr)                overflow <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- uart
   uart_st_t          uart_st, uart_st_n;
   logic [BAUD_W-1:0] baud_cnt, baud_n;
   logic [2:0]        bit_cnt, bit_n;
   logic [7:0]        shreg, shreg_n;
   logic              tx_n, busy_n, baud_end;

   assign baud_end = (baud_cnt == BAUD_W'(BAUD_DIV - 1));

   // UART state register; TX and tx_busy come straight from flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         uart_st  <= U_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= 3'd0;
         shreg    <= 8'd0;
         TX       <= 1'b1;
         tx_busy  <= 1'b0;
      end else begin
         uart_st  <= uart_st_n;
         baud_cnt <= baud_n;
         bit_cnt  <= bit_n;
         shreg    <= shreg_n;
         TX       <= tx_n;
         tx_busy  <= busy_n;
      end
   end

   // UART next-state: pop in IDLE, then start, 8 data bits LSB first, stop.
   always_comb begin
      uart_st_n = uart_st;
      baud_n    = baud_cnt + BAUD_W'(1);
      bit_n     = bit_cnt;
      shreg_n   = shreg;
      tx_n      = TX;
      busy_n    = tx_busy;
      pop_c     = 1'b0;
      case (uart_st)
         U_IDLE: begin
            baud_n = '0;
            if (fifo_level != '0) begin
               pop_c     = 1'b1;
               shreg_n   = tx_encode(mem[rd_ptr]);
               uart_st_n = U_START;
               tx_n      = 1'b0;
               busy_n    = 1'b1;
            end
         end
         U_START: begin
            if (baud_end) begin
               baud_n    = '0;
               bit_n     = 3'd0;
               uart_st_n = U_DATA;
               tx_n      = shreg[0];
            end
         end
         U_DATA: begin
            if (baud_end) begin
               baud_n = '0;
               if (bit_cnt == 3'd7) begin
                  uart_st_n = U_STOP;
                  tx_n      = 1'b1;
               end else begin
                  bit_n   = bit_cnt + 3'd1;
                  shreg_n = shreg >> 1;
                  tx_n    = shreg[1];
               end
            end
         end
         U_STOP: begin
            if (baud_end) begin
               baud_n    = '0;
               uart_st_n = U_IDLE;
               tx_n      = 1'b1;
               busy_n    = 1'b0;
            end
         end
         default: uart_st_n = U_IDLE;
      endcase
   end

endmodule
